fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, value driven on ifid_instr whenever ifid_valid is 0.
REQ-002 clock  input  1  rising-edge clock for all state in this block.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 pc_cur  input  32  current PC value from the program counter.
REQ-005 pc_load  output  1  load strobe to the program counter.
REQ-006 pc_next  output  32  value the program counter loads when pc_load is 1.
REQ-007 stall  input  1  hazard-unit request to freeze fetch and the IF/ID outputs.
REQ-008 redirect_valid  input  1  branch/jump resolved taken in EX, single-cycle pulse.
REQ-009 redirect_target  input  32  new fetch address, qualified by redirect_valid.
REQ-010 imem_req  output  1  instruction-memory request valid.
REQ-011 imem_addr  output  32  request address; equals pc_cur while imem_req is 1.
REQ-012 imem_ready  input  1  memory accepts the request this cycle (imem_req and imem_ready both 1).
REQ-013 imem_rvalid  input  1  response valid; exactly one response per accepted request, latency 1 or more cycles.
REQ-014 imem_rdata  input  32  instruction word, qualified by imem_rvalid.
REQ-015 ifid_valid  output  1  IF/ID register holds a live instruction.
REQ-016 ifid_pc  output  32  PC of the held instruction.
REQ-017 ifid_instr  output  32  held instruction word.

Function
REQ-018 The FSM SHALL have four states: S_REQ (imem_req=1), S_WAIT (awaiting rvalid), S_DROP (awaiting rvalid of a killed request), and S_HOLD (response captured while stall=1).
REQ-019 S_REQ SHALL go to S_WAIT on handshake; it SHALL stay in S_REQ otherwise.
REQ-020 S_WAIT with imem_rvalid=1 and stall=0 SHALL capture ifid_pc=pc_cur and ifid_instr=imem_rdata, set ifid_valid=1, pulse pc_load with pc_next=pc_cur+4, and go to S_REQ.
REQ-021 S_WAIT with imem_rvalid=1 and stall=1 SHALL capture the response internally without updating the IF/ID outputs or pulsing pc_load, then go to S_HOLD.
REQ-022 S_HOLD SHALL, on the first cycle with stall=0, move the captured response to the IF/ID outputs, pulse pc_load with pc_next=pc_cur+4, and go to S_REQ.
REQ-023 While stall=1, the IF/ID outputs SHALL hold their values and imem_req SHALL be 0 (no new request issued).
REQ-024 redirect_valid=1 in any state SHALL pulse pc_load with pc_next={redirect_target[31:2],2'b00}, taking priority over the +4 increment, and SHALL clear ifid_valid on the next edge regardless of stall.
REQ-025 Redirect in S_WAIT without imem_rvalid SHALL go to S_DROP; S_DROP SHALL discard the response and then go to S_REQ.
REQ-026 Redirect in the same cycle as imem_rvalid SHALL discard that response and go to S_REQ.
REQ-027 Redirect in S_HOLD SHALL discard the captured response and go to S_REQ.
REQ-028 In all other cases pc_load SHALL be 0; pc_next SHALL be a combinational function of the current state and inputs.
REQ-029 The +4 increment SHALL wrap modulo 2^32: pc_cur=32'hFFFFFFFC yields 32'h00000000.
REQ-030 While ifid_valid=0, ifid_instr SHALL equal NOP_INSTR.
REQ-031 The block SHALL accept back-to-back fetches: one instruction every 2 cycles with 1-cycle memory latency and stall=0.

Reset
REQ-032 reset=1 at a rising edge SHALL set state=S_REQ, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, and clear the internal capture buffer.
REQ-033 While reset=1, pc_load and imem_req SHALL be 0.
REQ-034 A response arriving after reset for a request issued before reset SHALL be ignored. Memory and PC are reset in the same cycle as this block.

Structure
REQ-035 Package fetch_pkg SHALL hold the state enum, PC_STEP=32'd4, and the default NOP constant.
REQ-036 The IF/ID output register (valid/pc/instr, with hold and flush inputs) SHALL be a sub-module named ifid_register.

Verification
REQ-037 Reset, then memory latency 1 with rdata=32'h00500093 at PC 0 -> ifid_valid=1, ifid_pc=0, ifid_instr=32'h00500093, pc_load pulse with pc_next=4.
REQ-038 stall=1 for 3 cycles while the response at PC 8 returns -> IF/ID unchanged, no pc_load, and no imem_req during the stall; the response appears the cycle after stall falls.
REQ-039 redirect_valid with target 32'h00000103 while in S_WAIT -> pc_next=32'h00000100 and ifid_valid=0; the late response is dropped and the next request is at 32'h100.
REQ-040 Redirect coincident with imem_rvalid and stall=1 -> response discarded, ifid_valid=0, pc_load=1.
REQ-041 pc_cur=32'hFFFFFFFC, response returned -> pc_next=32'h00000000.
REQ-042 reset asserted in S_WAIT, then a stale imem_rvalid -> ifid_valid stays 0 and imem_req issued for PC 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch slice: FSM encoding, PC step and default NOP.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] NOP_DEFAULT = 32'h00000013;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: flush beats load, hold freezes the contents.
module ifid_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    // instr is forced to NOP whenever valid drops, so downstream never sees a stale word.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load && !hold) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding imem request, stall hold buffer, redirect kill.
// imem handshake: a request transfers when imem_req && imem_ready; imem_req never depends on
// imem_ready, and it may be withdrawn before acceptance by stall or redirect.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic        pc_load,
    output logic [31:0] pc_next,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [1:0]  fsm_state
);

    fetch_state_t state, state_nxt;
    logic [31:0]  cap_instr;
    logic         capture;
    logic         deliver_now;
    logic         deliver_held;
    logic         ifid_load;
    logic [31:0]  load_instr;

    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        deliver_now  = 1'b0;
        deliver_held = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_req && imem_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        state_nxt = S_REQ;
                    end else if (stall) begin
                        capture   = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        deliver_now = 1'b1;
                        state_nxt   = S_REQ;
                    end
                end else if (redirect_valid) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_nxt = S_REQ;
                end else if (!stall) begin
                    deliver_held = 1'b1;
                    state_nxt    = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_REQ;
            cap_instr <= '0;
        end else begin
            state <= state_nxt;
            if (capture) cap_instr <= imem_rdata;
        end
    end

    // A redirect cycle must not issue: pc_cur is still the old, killed address.
    assign imem_req   = !reset && (state == S_REQ) && !stall && !redirect_valid;
    assign imem_addr  = pc_cur;
    assign ifid_load  = deliver_now || deliver_held;
    assign load_instr = deliver_held ? cap_instr : imem_rdata;
    assign pc_load    = !reset && (redirect_valid || ifid_load);
    assign pc_next    = redirect_valid ? align_word(redirect_target) : pc_cur + PC_STEP;
    assign fsm_state  = state;

    ifid_register #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clock      (clock),
        .reset      (reset),
        .hold       (stall),
        .flush      (redirect_valid),
        .load       (ifid_load),
        .load_pc    (pc_cur),
        .load_instr (load_instr),
        .valid      (ifid_valid),
        .pc         (ifid_pc),
        .instr      (ifid_instr)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: PC/memory environment plus a transaction-level fetch model.
module tb_fetch_controller;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset, stall, redirect_valid, imem_ready, imem_rvalid;
    logic [31:0] pc_cur, redirect_target, imem_rdata;
    logic        pc_load, imem_req, ifid_valid;
    logic [31:0] pc_next, imem_addr, ifid_pc, ifid_instr;
    logic [1:0]  fsm_state;

    always #5 clock = ~clock;

    fetch_controller dut (
        .clock           (clock),
        .reset           (reset),
        .pc_cur          (pc_cur),
        .pc_load         (pc_load),
        .pc_next         (pc_next),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_instr      (ifid_instr),
        .fsm_state       (fsm_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'd0) return 32'h00500093;
        return {addr[15:0], ~addr[15:0]} ^ 32'h0000_0013;
    endfunction

    // Environment: program counter register and a single-outstanding memory.
    logic [31:0] pc_r;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_next;

    // Reference model: outstanding fetch, held response, IF/ID contents, architectural PC.
    bit          m_out, m_killed, m_held, m_valid;
    logic [31:0] m_out_pc, m_held_pc, m_held_instr, m_ifpc, m_instr, m_pc;

    logic        last_load, last_req;
    logic [31:0] last_next, last_addr;

    task automatic cycle(input logic rst, input logic st, input logic rd, input logic [31:0] tgt,
                         input logic rdy, input logic stale);
        logic        rv, mem_resp, exp_req, exp_load, dlv, hs, d_load;
        logic [31:0] rdat, exp_next, dlv_pc, dlv_instr, d_next, d_addr;
        mem_resp = mem_busy && (mem_cnt == 1);
        rv       = mem_resp || stale;
        rdat     = mem_resp ? mem_word(mem_addr) : $urandom;
        reset           = rst;
        stall           = st;
        redirect_valid  = rd;
        redirect_target = tgt;
        imem_ready      = rdy;
        imem_rvalid     = rv;
        imem_rdata      = rdat;
        pc_cur          = pc_r;
        @(negedge clock);

        exp_req   = !rst && !st && !rd && !m_out && !m_held;
        dlv       = 1'b0;
        dlv_pc    = '0;
        dlv_instr = '0;
        if (!rst && !rd && !st) begin
            if (m_held) begin
                dlv = 1'b1; dlv_pc = m_held_pc; dlv_instr = m_held_instr;
            end else if (rv && m_out && !m_killed) begin
                dlv = 1'b1; dlv_pc = m_out_pc; dlv_instr = rdat;
            end
        end
        exp_load = !rst && (rd || dlv);
        exp_next = rd ? (tgt & ~32'd3) : dlv_pc + 32'd4;

        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("pc_load", pc_load, exp_load);
        if (exp_load) check("pc_next", pc_next, exp_next);
        check("ifid_valid", ifid_valid, m_valid);
        check("ifid_instr", ifid_instr, m_valid ? m_instr : NOP);
        if (m_valid) check("ifid_pc", ifid_pc, m_ifpc);

        d_load    = pc_load;
        d_next    = pc_next;
        d_addr    = imem_addr;
        hs        = imem_req && rdy;
        last_load = d_load;
        last_next = d_next;
        last_req  = imem_req;
        last_addr = imem_addr;

        if (rst) begin
            m_out = 0; m_killed = 0; m_held = 0; m_valid = 0;
            m_ifpc = '0; m_instr = NOP; m_pc = '0;
        end else begin
            if (rd) begin
                m_valid = 0;
                m_held  = 0;
                m_pc    = tgt & ~32'd3;
                if (m_out && rv) m_out = 0;
                else if (m_out) m_killed = 1;
            end else begin
                if (rv && m_out) begin
                    m_out = 0;
                    if (!m_killed && st) begin
                        m_held = 1; m_held_pc = m_out_pc; m_held_instr = rdat;
                    end
                end
                if (dlv) begin
                    m_held  = 0;
                    m_valid = 1;
                    m_ifpc  = dlv_pc;
                    m_instr = dlv_instr;
                    m_pc    = dlv_pc + 32'd4;
                end
            end
            if (exp_req && rdy) begin
                m_out = 1; m_out_pc = m_pc; m_killed = 0;
            end
        end

        if (rst) begin
            pc_r     = '0;
            mem_busy = 0;
        end else begin
            if (d_load) pc_r = d_next;
            if (mem_resp) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (hs) begin
                mem_busy = 1;
                mem_cnt  = (lat_next > 0) ? lat_next : int'($urandom_range(1, 3));
                mem_addr = d_addr;
            end
        end

        @(posedge clock);
        #1;
    endtask

    initial begin
        pc_r = '0; mem_busy = 0; mem_cnt = 0; mem_addr = '0; lat_next = 1;
        m_out = 0; m_killed = 0; m_held = 0; m_valid = 0;
        m_out_pc = '0; m_held_pc = '0; m_held_instr = '0; m_ifpc = '0; m_instr = NOP; m_pc = '0;
        reset = 1; stall = 0; redirect_valid = 0; redirect_target = '0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = '0; pc_cur = '0;
        @(posedge clock);
        #1;

        // Reset state
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_ifid_valid", ifid_valid, 1'b0);
        check("rst_ifid_pc", ifid_pc, 32'd0);
        check("rst_ifid_instr", ifid_instr, NOP);

        // First fetch at PC 0 with latency 1
        lat_next = 1;
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("first_pc_load", last_load, 1'b1);
        check("first_pc_next", last_next, 32'd4);
        check("first_valid", ifid_valid, 1'b1);
        check("first_pc", ifid_pc, 32'd0);
        check("first_instr", ifid_instr, 32'h00500093);

        // PC 4, then PC 8 returns under a 3-cycle stall
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 1, 0);
        check("stall_no_req", last_req, 1'b0);
        check("stall_ifid_pc", ifid_pc, 32'd4);
        cycle(0, 0, 0, 0, 1, 0);
        check("unstall_pc_next", last_next, 32'd12);
        check("unstall_ifid_pc", ifid_pc, 32'd8);
        check("unstall_instr", ifid_instr, mem_word(32'd8));

        // Redirect while waiting: late response dropped, next request at 0x100
        lat_next = 3;
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 32'h00000103, 1, 0);
        check("redir_pc_next", last_next, 32'h00000100);
        check("redir_flush", ifid_valid, 1'b0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        lat_next = 1;
        cycle(0, 0, 0, 0, 1, 0);
        check("redir_req", last_req, 1'b1);
        check("redir_addr", last_addr, 32'h00000100);
        cycle(0, 0, 0, 0, 1, 0);

        // Redirect coincident with rvalid and stall
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 1, 32'h00000200, 1, 0);
        check("coinc_pc_load", last_load, 1'b1);
        check("coinc_flush", ifid_valid, 1'b0);

        // Wrap of the +4 increment
        cycle(0, 0, 1, 32'hFFFFFFFC, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("wrap_pc_next", last_next, 32'h00000000);
        check("wrap_ifid_pc", ifid_pc, 32'hFFFFFFFC);

        // Randomized traffic against the model
        lat_next = 0;
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 9) < 7, 1'b0);
        end

        // Reset while waiting, then a stale response
        lat_next = 3;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        check("stale_req", last_req, 1'b1);
        check("stale_addr", last_addr, 32'd0);
        check("stale_valid", ifid_valid, 1'b0);
        cycle(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
